sreg_file: RTL and testbench
============================

# sreg_file

Special-register file for the core: the responder side of the special-register (SREG) read interface consumed by the Execute stage, plus the write port for move-to-special instructions. It holds a read-only core ID, 64-bit cycle and retired-instruction counters with tear-free hi/lo access, and eight scratch registers. Reads are issued one stage ahead of Execute, so the read result is valid exactly when the instruction reaches Execute.

## Interface
Parameters:
- REG_WIDTH, core::REG_WIDTH (32): SREG data width; counters are 2*REG_WIDTH bits.
- SREG_ADDR_WIDTH, 8: SREG address width.
- CORE_ID, 0: value returned by the ID register.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_req  in  1  read request, one per cycle maximum.
- rd_addr  in  SREG_ADDR_WIDTH  read address, sampled when rd_req=1.
- rd_valid  out  1  read data valid; pulses one cycle after rd_req.
- rd_val  out  REG_WIDTH  read data.
- wr_en  in  1  write strobe.
- wr_addr  in  SREG_ADDR_WIDTH  write address.
- wr_val  in  REG_WIDTH  write data.
- retire  in  1  one instruction retired this cycle.

## Operation
- Address map: 0x00 ID (RO), 0x01 CYCLE_LO, 0x02 CYCLE_HI, 0x03 INSTRET_LO, 0x04 INSTRET_HI, 0x08–0x0F SCRATCH0–7 (RW). All other addresses are unmapped.
- CYCLE increments by 1 on every clock with rst=0. INSTRET increments by 1 on every clock with rst=0 and retire=1. Both wrap from all-ones to 0.
- Snapshot: a read of CYCLE_LO returns the low half and copies the concurrent high half into CYCLE_SHADOW. A read of CYCLE_HI returns CYCLE_SHADOW, not the live high half. INSTRET uses the same mechanism with INSTRET_SHADOW.
- Writes:
  - Writes to the LO/HI counter halves load that half only.
  - A counter load takes priority over the increment in the same cycle; no increment occurs that cycle.
  - Writes to ID or to unmapped addresses are ignored.
- Reads of mapped addresses: rd_valid=1 and rd_val equal to the register value before the same edge's update. A read and a write to the same address in the same cycle returns the old value.
- Reads of unmapped addresses: rd_valid=0 and rd_val=0 in the following cycle.
- With rd_req=0, rd_valid=0 next cycle and rd_val holds its last value.

## Timing
- Read latency is 1 cycle: rd_req in cycle N gives rd_valid/rd_val in cycle N+1. Back-to-back reads are sustained every cycle.
- Writes take effect at the clock edge of the wr_en cycle and are visible to a read issued in cycle N+1.
- Reset values: rd_valid=0, rd_val=0, CYCLE=0, INSTRET=0, both shadows=0, all SCRATCH=0.
- Reset in the cycle of an rd_req: the request is dropped and rd_valid=0 next cycle.
- Reset in the cycle of a write: the write is dropped.
- Counting: the first clock with rst=0 gives CYCLE=1 after that edge. A CYCLE_LO read in the cycle where CYCLE=C returns C.

## Configuration
- SREG_PERF_COUNTERS_EN defined: CYCLE and INSTRET, their shadows and the retire input logic are built, as described above.
- SREG_PERF_COUNTERS_EN undefined: no counter or shadow flops are built. Addresses 0x01–0x04 behave as unmapped (rd_valid=0, rd_val=0, writes ignored). retire is unused.

## Structure
- Package SregPkg holds:
  - address constants SREG_ID, SREG_CYCLE_LO/HI, SREG_INSTRET_LO/HI, SREG_SCRATCH_BASE, SREG_SCRATCH_NUM=8;
  - function sreg_is_mapped(addr).
- Sub-module perf_counter64 (instantiated twice, for CYCLE and INSTRET) contains:
  - inputs inc, ld_lo, ld_hi, ld_val, snap;
  - outputs lo, hi_shadow, hi_live;
  - the increment, load priority and shadow capture logic.
- sreg_file itself contains the address decode, the scratch array and the registered read mux.

## Test plan
- Reset release, then a read of ID with CORE_ID=0x5 at cycle 3 → cycle 4: rd_valid=1, rd_val=0x5. A read of 0x20 → rd_valid=0, rd_val=0.
- Write SCRATCH3=0xDEADBEEF, read 0x0B next cycle → 0xDEADBEEF. Read and write of SCRATCH0 in the same cycle → old value 0, then 0x1234 on the next read.
- Load CYCLE_HI=0, CYCLE_LO=0xFFFFFFFE, then read LO once the counter has reached 0x0_FFFFFFFF → 0xFFFFFFFF. Read HI on the next cycle, after the counter has wrapped into the high half → shadow 0x0, not 0x1.
- retire high for 5 cycles with one gap, then read INSTRET_LO → 5. A write of 0x10 to INSTRET_LO with retire=1 → the next read returns 0x10.
- Assert rst while an rd_req and a SCRATCH write are pending → rd_valid=0, scratch stays 0, counters 0.
- Build without SREG_PERF_COUNTERS_EN → a read of 0x01 gives rd_valid=0, rd_val=0; a write to 0x03 has no effect.

Source files
------------

// File: rtl/sreg_file_pkg.sv
// Address map and decode helpers for the special-register file.
// Counter addresses decode as mapped only when SREG_PERF_COUNTERS_EN is defined.
package SregPkg;

    localparam logic [31:0] SREG_ID           = 32'h00;
    localparam logic [31:0] SREG_CYCLE_LO     = 32'h01;
    localparam logic [31:0] SREG_CYCLE_HI     = 32'h02;
    localparam logic [31:0] SREG_INSTRET_LO   = 32'h03;
    localparam logic [31:0] SREG_INSTRET_HI   = 32'h04;
    localparam logic [31:0] SREG_SCRATCH_BASE = 32'h08;
    localparam int          SREG_SCRATCH_NUM  = 8;

    function automatic logic sreg_is_scratch(input logic [31:0] addr);
        return (addr >= SREG_SCRATCH_BASE) &&
               (addr < SREG_SCRATCH_BASE + 32'(SREG_SCRATCH_NUM));
    endfunction

    function automatic logic sreg_is_counter(input logic [31:0] addr);
`ifdef SREG_PERF_COUNTERS_EN
        return (addr >= SREG_CYCLE_LO) && (addr <= SREG_INSTRET_HI);
`else
        return (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic logic sreg_is_mapped(input logic [31:0] addr);
        return (addr == SREG_ID) || sreg_is_scratch(addr) || sreg_is_counter(addr);
    endfunction

endpackage

// File: rtl/sreg_file_perf_counter64.sv
// Double-width free-running counter with per-half load and a high-half
// shadow captured on a low-half read, giving tear-free hi/lo access.
module perf_counter64 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         ld_lo,
    input  logic         ld_hi,
    input  logic [W-1:0] ld_val,
    input  logic         snap,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi_shadow,
    output logic [W-1:0] hi_live
);

    logic [2*W-1:0] cnt_q;
    logic [W-1:0]   shadow_q;

    // A load of either half suppresses the increment for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            if (ld_lo) cnt_q[W-1:0]   <= ld_val;
            if (ld_hi) cnt_q[2*W-1:W] <= ld_val;
            if (!ld_lo && !ld_hi && inc) cnt_q <= cnt_q + {{(2*W-1){1'b0}}, 1'b1};
            if (snap) shadow_q <= cnt_q[2*W-1:W];
        end
    end

    assign lo        = cnt_q[W-1:0];
    assign hi_live   = cnt_q[2*W-1:W];
    assign hi_shadow = shadow_q;

endmodule

// File: rtl/sreg_file.sv
// Special-register file: core ID, scratch registers and (with
// SREG_PERF_COUNTERS_EN) CYCLE/INSTRET counters, with a one-cycle registered read.
module sreg_file
    import SregPkg::*;
#(
    parameter int          REG_WIDTH       = 32,
    parameter int          SREG_ADDR_WIDTH = 8,
    parameter int unsigned CORE_ID         = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req,
    input  logic [SREG_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rd_valid,
    output logic [REG_WIDTH-1:0]       rd_val,
    input  logic                       wr_en,
    input  logic [SREG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [REG_WIDTH-1:0]       wr_val,
    input  logic                       retire
);

    localparam int SCR_IW = $clog2(SREG_SCRATCH_NUM);

    logic [31:0]          rd_a;
    logic [31:0]          wr_a;
    logic [REG_WIDTH-1:0] scratch_q [SREG_SCRATCH_NUM];
    logic [REG_WIDTH-1:0] rd_data;

    assign rd_a = 32'(rd_addr);
    assign wr_a = 32'(wr_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SREG_SCRATCH_NUM; i++) scratch_q[i] <= '0;
        end else if (wr_en && sreg_is_scratch(wr_a)) begin
            scratch_q[wr_a[SCR_IW-1:0]] <= wr_val;
        end
    end

`ifdef SREG_PERF_COUNTERS_EN
    logic [REG_WIDTH-1:0] cycle_lo, cycle_shadow, cycle_hi_unused;
    logic [REG_WIDTH-1:0] instret_lo, instret_shadow, instret_hi_unused;

    perf_counter64 #(.W(REG_WIDTH)) u_cycle (
        .clk       (clk),
        .rst       (rst),
        .inc       (1'b1),
        .ld_lo     (wr_en && (wr_a == SREG_CYCLE_LO)),
        .ld_hi     (wr_en && (wr_a == SREG_CYCLE_HI)),
        .ld_val    (wr_val),
        .snap      (rd_req && (rd_a == SREG_CYCLE_LO)),
        .lo        (cycle_lo),
        .hi_shadow (cycle_shadow),
        .hi_live   (cycle_hi_unused)
    );

    perf_counter64 #(.W(REG_WIDTH)) u_instret (
        .clk       (clk),
        .rst       (rst),
        .inc       (retire),
        .ld_lo     (wr_en && (wr_a == SREG_INSTRET_LO)),
        .ld_hi     (wr_en && (wr_a == SREG_INSTRET_HI)),
        .ld_val    (wr_val),
        .snap      (rd_req && (rd_a == SREG_INSTRET_LO)),
        .lo        (instret_lo),
        .hi_shadow (instret_shadow),
        .hi_live   (instret_hi_unused)
    );
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    always_comb begin
        rd_data = '0;
        if (rd_a == SREG_ID) begin
            rd_data = REG_WIDTH'(CORE_ID);
        end else if (sreg_is_scratch(rd_a)) begin
            rd_data = scratch_q[rd_a[SCR_IW-1:0]];
        end
`ifdef SREG_PERF_COUNTERS_EN
        else if (rd_a == SREG_CYCLE_LO)   rd_data = cycle_lo;
        else if (rd_a == SREG_CYCLE_HI)   rd_data = cycle_shadow;
        else if (rd_a == SREG_INSTRET_LO) rd_data = instret_lo;
        else if (rd_a == SREG_INSTRET_HI) rd_data = instret_shadow;
`endif
    end

    // Read protocol: no backpressure. rd_req in cycle N yields rd_valid/rd_val
    // in N+1; unmapped reads return valid=0 with data 0; idle cycles hold rd_val.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_val   <= '0;
        end else if (rd_req) begin
            rd_valid <= sreg_is_mapped(rd_a);
            rd_val   <= rd_data;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sreg_file.sv
// Directed-vector bench for sreg_file; counter checks follow SREG_PERF_COUNTERS_EN.
module tb_sreg_file;

    localparam int RW     = 32;
    localparam int AW     = 8;
    localparam int ID_VAL = 5;
    localparam int NVEC   = 15;

    logic          clk;
    logic          rst;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [RW-1:0] rd_val;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_val;
    logic          retire;

    sreg_file #(
        .REG_WIDTH       (RW),
        .SREG_ADDR_WIDTH (AW),
        .CORE_ID         (ID_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_val   (rd_val),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_val   (wr_val),
        .retire   (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [RW-1:0] wv;
        logic          rq;
        logic [AW-1:0] ra;
        logic          ev;
        logic [RW-1:0] evl;
    } vec_t;

    vec_t          vecs [NVEC];
    logic [RW:0]   exp_q [$];
    int            total = 0;
    int            bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name);
        logic [RW:0] exp;
        exp = exp_q.pop_front();
        total++;
        if ({rd_valid, rd_val} !== exp) begin
            bad++;
            $display("FAIL %s: got valid=%0b val=%h, want valid=%0b val=%h",
                     name, rd_valid, rd_val, exp[RW], exp[RW-1:0]);
        end
    endtask

    task automatic op(input logic we, input logic [AW-1:0] wa, input logic [RW-1:0] wv,
                      input logic rq, input logic [AW-1:0] ra,
                      input logic ev, input logic [RW-1:0] evl, input string name);
        wr_en   = we;
        wr_addr = wa;
        wr_val  = wv;
        rd_req  = rq;
        rd_addr = ra;
        exp_q.push_back({ev, evl});
        tick();
        wr_en  = 1'b0;
        rd_req = 1'b0;
        check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] pat;

        vecs[0]  = '{1'b1, 8'h0B, 32'hDEADBEEF, 1'b0, 8'h00, 1'b0, 32'h5};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,        1'b1, 8'h0B, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 8'h08, 32'h1234,     1'b1, 8'h08, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 8'h00, 32'h0,        1'b1, 8'h08, 1'b1, 32'h1234};
        vecs[4]  = '{1'b0, 8'h00, 32'h0,        1'b1, 8'h20, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 8'h00, 32'h77,       1'b1, 8'h00, 1'b1, 32'h5};
        vecs[7]  = '{1'b0, 8'h00, 32'h0,        1'b1, 8'h00, 1'b1, 32'h5};
        vecs[8]  = '{1'b1, 8'h20, 32'h99,       1'b1, 8'h0F, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 8'h0F, 32'hCAFEF00D, 1'b1, 8'h07, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 8'h00, 32'h0,        1'b1, 8'h0F, 1'b1, 32'hCAFEF00D};
        vecs[11] = '{1'b0, 8'h00, 32'h0,        1'b1, 8'h0B, 1'b1, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 32'hDEADBEEF};
        vecs[13] = '{1'b0, 8'h00, 32'h0,        1'b1, 8'hFF, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 8'h00, 32'h0,        1'b1, 8'h08, 1'b1, 32'h1234};

        rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_val = '0; retire = 1'b0;
        repeat (3) tick();
        exp_q.push_back({1'b0, 32'h0});
        check("reset_out");
        rst = 1'b0;

`ifdef SREG_PERF_COUNTERS_EN
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h01, 1'b1, 32'h0, "cycle_first");
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h01, 1'b1, 32'h1, "cycle_second");
`else
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h01, 1'b0, 32'h0, "cycle_first");
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h01, 1'b0, 32'h0, "cycle_second");
`endif
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b1, 32'h5, "id_read");

        for (int i = 0; i < NVEC; i++) begin
            op(vecs[i].we, vecs[i].wa, vecs[i].wv, vecs[i].rq, vecs[i].ra,
               vecs[i].ev, vecs[i].evl, $sformatf("vec%0d", i));
        end

`ifdef SREG_PERF_COUNTERS_EN
        op(1'b1, 8'h02, 32'h0,        1'b1, 8'h00, 1'b1, 32'h5, "cyc_ld_hi");
        op(1'b1, 8'h01, 32'hFFFFFFFE, 1'b1, 8'h00, 1'b1, 32'h5, "cyc_ld_lo");
        op(1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 32'h5, "idle_hold");
        op(1'b0, 8'h00, 32'h0,        1'b1, 8'h01, 1'b1, 32'hFFFFFFFF, "cyc_lo_pre_wrap");
        op(1'b0, 8'h00, 32'h0,        1'b1, 8'h02, 1'b1, 32'h0, "cyc_hi_shadow");
        op(1'b0, 8'h00, 32'h0,        1'b1, 8'h01, 1'b1, 32'h1, "cyc_lo_post_wrap");
        op(1'b0, 8'h00, 32'h0,        1'b1, 8'h02, 1'b1, 32'h1, "cyc_hi_post_wrap");

        pat = 6'b110111;
        for (int i = 0; i < 6; i++) begin
            retire = pat[i];
            tick();
        end
        retire = 1'b0;
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h03, 1'b1, 32'h5, "instret_lo");
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h04, 1'b1, 32'h0, "instret_hi");
        retire = 1'b1;
        op(1'b1, 8'h03, 32'h10, 1'b1, 8'h00, 1'b1, 32'h5, "instret_ld");
        retire = 1'b0;
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h03, 1'b1, 32'h10, "instret_ld_wins");
`else
        pat = 6'b110111;
        for (int i = 0; i < 6; i++) begin
            retire = pat[i];
            tick();
        end
        retire = 1'b0;
        op(1'b1, 8'h03, 32'h55, 1'b1, 8'h00, 1'b1, 32'h5, "nperf_wr03");
        op(1'b0, 8'h00, 32'h0,  1'b1, 8'h0B, 1'b1, 32'hDEADBEEF, "nperf_scr3");
        op(1'b0, 8'h00, 32'h0,  1'b1, 8'h01, 1'b0, 32'h0, "nperf_rd01");
        op(1'b0, 8'h00, 32'h0,  1'b1, 8'h03, 1'b0, 32'h0, "nperf_rd03");
        op(1'b1, 8'h04, 32'h66, 1'b1, 8'h04, 1'b0, 32'h0, "nperf_rd04");
`endif

        // Reset landing on a pending read and scratch write.
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h0B, 1'b1, 32'hDEADBEEF, "pre_rst");
        rst = 1'b1;
        op(1'b1, 8'h0D, 32'hAA, 1'b1, 8'h0D, 1'b0, 32'h0, "rst_drop_rd");
        rst = 1'b0;
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h0D, 1'b1, 32'h0, "rst_drop_wr");
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h0B, 1'b1, 32'h0, "rst_scr3");
`ifdef SREG_PERF_COUNTERS_EN
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h01, 1'b1, 32'h2, "rst_cycle");
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h02, 1'b1, 32'h0, "rst_cycle_hi");
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h03, 1'b1, 32'h0, "rst_instret");
`else
        op(1'b0, 8'h00, 32'h0, 1'b1, 8'h02, 1'b0, 32'h0, "rst_cycle_hi");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
